// File: rtl/noc_queue_pkg.sv
// Shared constants, flit typedef and sizing helper for the NoC virtual-channel queue.
package noc_queue_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned DEPTH_DEF  = 4;
    localparam int unsigned NUM_VC_DEF = 2;

    typedef logic [DATA_W_DEF-1:0] flit_t;

    // VC index width; a single VC still needs a 1-bit select port.
    function automatic int unsigned vc_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/noc_fifo_slice.sv
// One virtual-channel FIFO: storage, wrapping pointers and occupancy count.
module noc_fifo_slice #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push) mem[wr_ptr] <= data_i;
    end

    assign head_o  = mem[rd_ptr];
    assign full_o  = (count == CNT_W'(DEPTH));
    assign empty_o = (count == '0);

endmodule

// File: rtl/noc_vc_queue.sv
// Multi-VC input queue with registered pop data and per-VC credit return.
// Optional sticky error flag err_o enabled by defining NOC_QUEUE_ERR_EN.
module noc_vc_queue
    import noc_queue_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned NUM_VC = NUM_VC_DEF,
    localparam int unsigned VC_W  = vc_width(NUM_VC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_req_i,
    input  logic [VC_W-1:0]   push_vc_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_req_i,
    input  logic [VC_W-1:0]   pop_vc_i,
    output logic [DATA_W-1:0] data_o,
    output logic              data_valid_o,
    output logic [NUM_VC-1:0] full_o,
    output logic [NUM_VC-1:0] empty_o,
    output logic [NUM_VC-1:0] credit_o
`ifdef NOC_QUEUE_ERR_EN
   ,output logic              err_o
`endif
);

    logic [NUM_VC-1:0] push_acc;
    logic [NUM_VC-1:0] pop_acc;
    logic [DATA_W-1:0] head [NUM_VC];
    logic [DATA_W-1:0] pop_data;

    // Out-of-range VC indices match no slice and are therefore rejected.
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        assign push_acc[v] = push_req_i && (push_vc_i == VC_W'(v)) && !full_o[v];
        assign pop_acc[v]  = pop_req_i  && (pop_vc_i  == VC_W'(v)) && !empty_o[v];

        noc_fifo_slice #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_slice (
            .clk     (clk),
            .rst     (rst),
            .push    (push_acc[v]),
            .pop     (pop_acc[v]),
            .data_i  (data_i),
            .head_o  (head[v]),
            .full_o  (full_o[v]),
            .empty_o (empty_o[v])
        );
    end

    always_comb begin
        pop_data = '0;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            if (pop_acc[v]) pop_data = head[v];
        end
    end

    // data_o holds its last value when no pop is accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_o       <= '0;
            data_valid_o <= 1'b0;
            credit_o     <= '0;
        end else begin
            data_valid_o <= |pop_acc;
            credit_o     <= pop_acc;
            if (|pop_acc) data_o <= pop_data;
        end
    end

`ifdef NOC_QUEUE_ERR_EN
    // A request that no slice accepted was full, empty or out of range.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_o <= 1'b0;
        end else if ((push_req_i && !(|push_acc)) || (pop_req_i && !(|pop_acc))) begin
            err_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_noc_vc_queue.sv
// Self-checking bench for noc_vc_queue against a per-VC queue model.
module tb_noc_vc_queue;
    import noc_queue_pkg::*;

    localparam int DEPTH  = 4;
    localparam int NUM_VC = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              push_req_i;
    logic [0:0]        push_vc_i;
    flit_t             data_i;
    logic              pop_req_i;
    logic [0:0]        pop_vc_i;
    flit_t             data_o;
    logic              data_valid_o;
    logic [NUM_VC-1:0] full_o;
    logic [NUM_VC-1:0] empty_o;
    logic [NUM_VC-1:0] credit_o;
`ifdef NOC_QUEUE_ERR_EN
    logic              err_o;
`endif

    noc_vc_queue dut (
        .clk          (clk),
        .rst          (rst),
        .push_req_i   (push_req_i),
        .push_vc_i    (push_vc_i),
        .data_i       (data_i),
        .pop_req_i    (pop_req_i),
        .pop_vc_i     (pop_vc_i),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .full_o       (full_o),
        .empty_o      (empty_o),
        .credit_o     (credit_o)
`ifdef NOC_QUEUE_ERR_EN
       ,.err_o        (err_o)
`endif
    );

    always #5 clk = ~clk;

    flit_t mq [NUM_VC][$];
    flit_t exp_data;
    logic  exp_err;
    int    checks;
    int    failures;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; the model decides acceptance from queue sizes at cycle start.
    task automatic step(input bit rs, input bit pu, input int pvc, input flit_t d,
                        input bit po, input int ovc, input string tag);
        bit push_ok;
        bit pop_ok;
        logic [NUM_VC-1:0] e_full;
        logic [NUM_VC-1:0] e_empty;
        logic [NUM_VC-1:0] e_credit;
        @(negedge clk);
        rst        = rs;
        push_req_i = pu;
        push_vc_i  = pvc[0];
        data_i     = d;
        pop_req_i  = po;
        pop_vc_i   = ovc[0];
        push_ok  = 1'b0;
        pop_ok   = 1'b0;
        e_credit = '0;
        if (rs && pu && pvc < NUM_VC) push_ok = (mq[pvc].size() < DEPTH);
        if (rs && po && ovc < NUM_VC) pop_ok  = (mq[ovc].size() > 0);
        if (!rs) begin
            for (int v = 0; v < NUM_VC; v++) mq[v].delete();
            exp_data = '0;
            exp_err  = 1'b0;
        end else begin
            if (pop_ok) begin
                exp_data      = mq[ovc].pop_front();
                e_credit[ovc] = 1'b1;
            end
            if (push_ok) mq[pvc].push_back(d);
            if ((pu && !push_ok) || (po && !pop_ok)) exp_err = 1'b1;
        end
        for (int v = 0; v < NUM_VC; v++) begin
            e_full[v]  = (mq[v].size() == DEPTH);
            e_empty[v] = (mq[v].size() == 0);
        end
        @(posedge clk);
        #1;
        chk({tag, ".valid"},  32'(data_valid_o), 32'(pop_ok));
        chk({tag, ".credit"}, 32'(credit_o),     32'(e_credit));
        chk({tag, ".data"},   32'(data_o),       32'(exp_data));
        chk({tag, ".full"},   32'(full_o),       32'(e_full));
        chk({tag, ".empty"},  32'(empty_o),      32'(e_empty));
`ifdef NOC_QUEUE_ERR_EN
        chk({tag, ".err"},    32'(err_o),        32'(exp_err));
`endif
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        exp_data   = '0;
        exp_err    = 1'b0;
        rst        = 1'b0;
        push_req_i = 1'b0;
        push_vc_i  = '0;
        data_i     = '0;
        pop_req_i  = 1'b0;
        pop_vc_i   = '0;

        // Reset with requests present: they must be ignored.
        step(0, 1, 0, 16'h5555, 1, 0, "rst0");
        step(0, 0, 0, 16'h0000, 0, 0, "rst1");
        chk("rst.empty_all", 32'(empty_o), 32'(2'b11));
        chk("rst.full_none", 32'(full_o),  32'(2'b00));

        // Fill VC0, overflow push dropped, drain in order.
        for (int i = 1; i <= 4; i++) step(1, 1, 0, flit_t'(16'hA000 + i), 0, 0, "fill");
        chk("fill.full0", 32'(full_o[0]), 32'(1));
        step(1, 1, 0, 16'hA005, 0, 0, "ovfl");
        for (int i = 1; i <= 4; i++) begin
            step(1, 0, 0, 16'h0000, 1, 0, "drain");
            chk("drain.order", 32'(data_o), 32'(16'hA000 + i));
        end

        // Interleaved VCs popped in reverse order.
        step(1, 1, 0, 16'h1111, 0, 0, "il.push0");
        step(1, 1, 1, 16'h2222, 0, 0, "il.push1");
        step(1, 0, 0, 16'h0000, 1, 1, "il.pop1");
        chk("il.pop1.credit", 32'(credit_o), 32'(2'b10));
        step(1, 0, 0, 16'h0000, 1, 0, "il.pop0");
        chk("il.pop0.credit", 32'(credit_o), 32'(2'b01));

        // Simultaneous push/pop on a one-entry VC.
        step(1, 1, 0, 16'hBEEF, 0, 0, "sp.push");
        step(1, 1, 0, 16'hCAFE, 1, 0, "sp.both");
        chk("sp.both.data", 32'(data_o), 32'(16'hBEEF));
        step(1, 0, 0, 16'h0000, 1, 0, "sp.pop");
        chk("sp.pop.data", 32'(data_o), 32'(16'hCAFE));

        // Pop of an empty VC after reset.
        step(0, 0, 0, 16'h0000, 0, 0, "e.rst");
        step(1, 0, 0, 16'h0000, 1, 1, "e.pop1");
        step(1, 0, 0, 16'h0000, 0, 0, "e.idle");

        // Mid-operation reset discards stored flits.
        for (int i = 0; i < 3; i++) step(1, 1, 0, flit_t'(16'h3000 + i), 0, 0, "mr.fill");
        step(0, 0, 0, 16'h0000, 0, 0, "mr.rst");
        chk("mr.empty_all", 32'(empty_o), 32'(2'b11));
        step(1, 0, 0, 16'h0000, 1, 0, "mr.pop");

        // Continuous streaming across pointer wrap-around.
        for (int i = 0; i <= 3 * DEPTH; i++)
            step(1, i < 3 * DEPTH, 0, flit_t'(16'h4000 + i), i > 0, 0, "wrap");

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 59) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, NUM_VC - 1),
                 flit_t'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, NUM_VC - 1), "rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/noc_vc_queue.md
NOC_VC_QUEUE -- requirements
Module: noc_vc_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 16: flit width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: entries per virtual channel; power of two, at least 2.
REQ-003 SHALL have parameter NUM_VC, default 2: number of independent virtual-channel queues; VC_W = max(1, clog2(NUM_VC)).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port push_req_i  input  1  write data_i into VC push_vc_i this cycle.
REQ-007 SHALL have port push_vc_i  input  VC_W  target VC of push.
REQ-008 SHALL have port data_i  input  DATA_W  flit to push.
REQ-009 SHALL have port pop_req_i  input  1  read head of VC pop_vc_i.
REQ-010 SHALL have port pop_vc_i  input  VC_W  source VC of pop.
REQ-011 SHALL have port data_o  output  DATA_W  popped flit, registered.
REQ-012 SHALL have port data_valid_o  output  1  data_o holds a flit popped in the previous cycle.
REQ-013 SHALL have port full_o  output  NUM_VC  per-VC full flag.
REQ-014 SHALL have port empty_o  output  NUM_VC  per-VC empty flag.
REQ-015 SHALL have port credit_o  output  NUM_VC  one-cycle credit-return pulse per VC to the upstream router.

Function
REQ-016 Each VC SHALL be an independent FIFO with its own read pointer, write pointer and occupancy count (0..DEPTH).
REQ-017 A push SHALL be accepted only if the target VC is not full at the start of the cycle; a push to a full VC is dropped and changes no state, even if the same VC is popped in that cycle.
REQ-018 A pop SHALL be accepted only if the source VC is not empty at the start of the cycle; a pop from an empty VC changes no state.
REQ-019 An accepted pop SHALL drive data_o with the head flit and data_valid_o high in the next cycle (latency 1); otherwise data_valid_o is low next cycle and data_o holds its last value.
REQ-020 An accepted pop from VC v SHALL pulse credit_o[v] high for exactly one cycle, coincident with data_valid_o.
REQ-021 Simultaneous accepted push and pop on the same VC SHALL leave its count unchanged and preserve FIFO order; when the VC holds exactly one entry, the old head is popped and the new flit becomes the head.
REQ-022 Pointers SHALL wrap modulo DEPTH; count SHALL be DEPTH+1-safe (width clog2(DEPTH)+1).
REQ-023 full_o[v] SHALL equal (count==DEPTH) and empty_o[v] SHALL equal (count==0), both derived from registered count with no combinational path from inputs.
REQ-024 push_vc_i or pop_vc_i values >= NUM_VC SHALL be treated as a rejected request.

Reset
REQ-025 While rst is low at a rising edge, all pointers and counts SHALL clear to 0, empty_o is all ones, full_o is all zeros, data_valid_o, credit_o and data_o are 0.
REQ-026 Reset asserted mid-operation SHALL discard all stored flits; requests in the reset cycle are ignored.

Configuration
REQ-027 With NOC_QUEUE_ERR_EN defined, the block SHALL add output err_o (1 bit, reset 0), sticky-set on any push to a full VC, pop from an empty VC, or out-of-range VC index, cleared only by reset.
REQ-028 Without NOC_QUEUE_ERR_EN, err_o and its logic SHALL be absent; data behaviour is identical.

Structure
REQ-029 A shared package noc_queue_pkg SHALL hold the default parameter constants and the flit typedef.
REQ-030 Per-VC storage and pointer logic SHALL be a sub-module noc_fifo_slice, instantiated NUM_VC times; the top level holds request decode, output mux/register, credit pulses and the error flag.

Verification
REQ-031 Reset, then push 0xA001..0xA004 to VC0 -> full_o[0]=1 after the 4th push; 5th push 0xA005 dropped; four pops return A001..A004 in order with 1-cycle latency.
REQ-032 Interleave pushes 0x1111 to VC0 and 0x2222 to VC1, pop VC1 then VC0 -> data_o 0x2222 then 0x1111, with credit_o = 2'b10 then 2'b01.
REQ-033 VC0 holds one entry 0xBEEF; push 0xCAFE and pop VC0 in the same cycle -> data_o=0xBEEF, count stays 1, next pop returns 0xCAFE.
REQ-034 Pop empty VC1 after reset -> data_valid_o=0, credit_o=0; with NOC_QUEUE_ERR_EN, err_o=1 from the next cycle until reset.
REQ-035 Fill VC0 with 3 entries, assert rst low for one cycle -> empty_o=2'b11, data_valid_o=0, then a pop of VC0 is rejected.
REQ-036 Push/pop VC0 continuously for 3*DEPTH flits with counting data -> no loss or reordering across pointer wrap-around.
